// File: rtl/pnc_pkg.sv
// Shared PNC definitions: engine target codes, address region codes and the
// arbiter owner states used by the request arbiter and the address control path.
package pnc_pkg;

    typedef enum logic {
        OWN_HOST = 1'b0,
        OWN_SWU  = 1'b1
    } owner_e;

    localparam logic [1:0] TGT_SYNAPSE = 2'd0;
    localparam logic [1:0] TGT_SOMA    = 2'd1;
    localparam logic [1:0] TGT_STDP    = 2'd2;

    localparam logic [3:0] REGION_SYNAPSE = 4'h1;
    localparam logic [3:0] REGION_SOMA    = 4'h2;
    localparam logic [3:0] REGION_STDP    = 4'h3;

endpackage

// File: rtl/pnc_req_arbiter_if.sv
// Host, SWU and issue-side handshake bundle of the PNC request arbiter.
// The slave modport is the arbiter's view, the master modport is the surrounding system's view.
interface pnc_req_arbiter_if #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int SWU_DATA_W = 8
);
    logic                  host_valid;
    logic                  host_ready;
    logic [ADDR_W-1:0]     host_addr;
    logic [DATA_W-1:0]     host_data;

    logic                  swu_valid;
    logic                  swu_ready;
    logic [ADDR_W-1:0]     swu_addr;
    logic [SWU_DATA_W-1:0] swu_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_W-1:0]     out_addr;
    logic [DATA_W-1:0]     out_data;
    logic                  out_src;
    logic [1:0]            out_tgt;
    logic                  err_drop;

    modport slave (
        input  host_valid, host_addr, host_data,
        output host_ready,
        input  swu_valid, swu_addr, swu_data,
        output swu_ready,
        output out_valid, out_addr, out_data, out_src, out_tgt, err_drop,
        input  out_ready
    );

    modport master (
        output host_valid, host_addr, host_data,
        input  host_ready,
        output swu_valid, swu_addr, swu_data,
        input  swu_ready,
        input  out_valid, out_addr, out_data, out_src, out_tgt, err_drop,
        output out_ready
    );

endinterface

// File: rtl/pnc_tgt_decode.sv
// Combinational decode of an address region nibble into the PNC engine target.
// Shared between the request arbiter and the PNC address control path.
module pnc_tgt_decode
    import pnc_pkg::*;
(
    input  logic [3:0] region,
    output logic       hit,
    output logic [1:0] tgt
);

    always_comb begin
        hit = 1'b1;
        tgt = TGT_SYNAPSE;
        case (region)
            REGION_SYNAPSE: tgt = TGT_SYNAPSE;
            REGION_SOMA:    tgt = TGT_SOMA;
            REGION_STDP:    tgt = TGT_STDP;
            default:        hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/pnc_req_arbiter.sv
// Round-robin host/SWU arbiter with a burst limit feeding a one-entry issue register
// in front of the PNC write path. Defining PNC_ARB_STATS_EN adds saturating grant/drop counters.
module pnc_req_arbiter
    import pnc_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int SWU_DATA_W = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic kill,
    pnc_req_arbiter_if.slave bus
`ifdef PNC_ARB_STATS_EN
    ,
    output logic [15:0] host_gnt_cnt,
    output logic [15:0] swu_gnt_cnt,
    output logic [15:0] drop_cnt
`endif
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    owner_e            owner_q;
    owner_e            owner_d;
    logic [3:0]        burst_q;
    logic [3:0]        burst_d;

    logic              owner_valid;
    logic              other_valid;
    logic              keep_grant;
    logic              take_grant;
    logic              grant_host;
    logic              grant_swu;

    logic              slot_free;
    logic              accept_en;
    logic              host_fire;
    logic              swu_fire;
    logic              any_fire;
    logic              loser_valid;
    owner_e            winner;

    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              tgt_hit;
    logic [1:0]        tgt_code;

    assign slot_free = !bus.out_valid || bus.out_ready;
    assign accept_en = slot_free && !kill && !rst;

    // The owner holds the grant until it goes idle or exhausts its burst while the other waits.
    always_comb begin
        owner_valid = (owner_q == OWN_HOST) ? bus.host_valid : bus.swu_valid;
        other_valid = (owner_q == OWN_HOST) ? bus.swu_valid  : bus.host_valid;
        keep_grant  = owner_valid && (!other_valid || (burst_q < BURST_MAX));
        take_grant  = !keep_grant && other_valid;
        grant_host  = (owner_q == OWN_HOST) ? keep_grant : take_grant;
        grant_swu   = (owner_q == OWN_SWU)  ? keep_grant : take_grant;
    end

    always_comb begin
        bus.host_ready = accept_en && grant_host;
        bus.swu_ready  = accept_en && grant_swu;
    end

    assign host_fire   = bus.host_valid && bus.host_ready;
    assign swu_fire    = bus.swu_valid && bus.swu_ready;
    assign any_fire    = host_fire || swu_fire;
    assign winner      = host_fire ? OWN_HOST : OWN_SWU;
    assign loser_valid = host_fire ? bus.swu_valid : bus.host_valid;

    always_comb begin
        owner_d = owner_q;
        burst_d = burst_q;
        if (any_fire) begin
            owner_d = winner;
            if (!loser_valid) begin
                burst_d = 4'd0;
            end else if (winner != owner_q) begin
                burst_d = 4'd1;
            end else if (burst_q < BURST_MAX) begin
                burst_d = burst_q + 4'd1;
            end
        end
    end

    // kill keeps the owner so the flushed requester resumes first, with a fresh burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_SWU;
            burst_q <= 4'd0;
        end else if (kill) begin
            burst_q <= 4'd0;
        end else begin
            owner_q <= owner_d;
            burst_q <= burst_d;
        end
    end

    assign sel_addr = grant_host ? bus.host_addr : bus.swu_addr;
    assign sel_data = grant_host ? bus.host_data
                                 : {{(DATA_W-SWU_DATA_W){1'b0}}, bus.swu_data};

    pnc_tgt_decode u_decode (
        .region (sel_addr[15:12]),
        .hit    (tgt_hit),
        .tgt    (tgt_code)
    );

    // Unmapped requests complete their handshake but never occupy the issue slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_addr  <= '0;
            bus.out_data  <= '0;
            bus.out_src   <= 1'b0;
            bus.out_tgt   <= TGT_SYNAPSE;
            bus.err_drop  <= 1'b0;
        end else if (kill) begin
            bus.out_valid <= 1'b0;
            bus.err_drop  <= 1'b0;
        end else begin
            bus.err_drop <= any_fire && !tgt_hit;
            if (any_fire && tgt_hit) begin
                bus.out_valid <= 1'b1;
                bus.out_addr  <= sel_addr;
                bus.out_data  <= sel_data;
                bus.out_src   <= grant_swu;
                bus.out_tgt   <= tgt_code;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

`ifdef PNC_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            host_gnt_cnt <= 16'd0;
            swu_gnt_cnt  <= 16'd0;
            drop_cnt     <= 16'd0;
        end else begin
            if (host_fire && (host_gnt_cnt != 16'hFFFF)) host_gnt_cnt <= host_gnt_cnt + 16'd1;
            if (swu_fire && (swu_gnt_cnt != 16'hFFFF))   swu_gnt_cnt  <= swu_gnt_cnt + 16'd1;
            if (any_fire && !tgt_hit && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pnc_req_arbiter.sv
// Testbench for pnc_req_arbiter: directed vector table, multi-cycle corner sequences
// and randomized traffic checked against a behavioural arbitration/issue model.
module tb_pnc_req_arbiter;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 32;
    localparam int SWU_DATA_W = 8;
    localparam int MAX_BURST  = 4;
    localparam int NV         = 13;

    typedef struct packed {
        logic        hv;
        logic [15:0] ha;
        logic [31:0] hd;
        logic        sv;
        logic [15:0] sa;
        logic [7:0]  sd;
        logic        ordy;
        logic        kl;
        logic        rs;
    } stim_t;

    typedef struct packed {
        stim_t       in;
        logic        hr;
        logic        sr;
        logic        ov;
        logic        src;
        logic [1:0]  tgt;
        logic [15:0] addr;
        logic [31:0] data;
        logic        err;
    } vec_t;

    logic clk;
    logic rst;
    logic kill;

    pnc_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SWU_DATA_W(SWU_DATA_W)) bus ();

`ifdef PNC_ARB_STATS_EN
    logic [15:0] host_gnt_cnt;
    logic [15:0] swu_gnt_cnt;
    logic [15:0] drop_cnt;
`endif

    pnc_req_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SWU_DATA_W(SWU_DATA_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .kill (kill),
        .bus  (bus)
`ifdef PNC_ARB_STATS_EN
        ,
        .host_gnt_cnt (host_gnt_cnt),
        .swu_gnt_cnt  (swu_gnt_cnt),
        .drop_cnt     (drop_cnt)
`endif
    );

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Reference model state: owner 0=host 1=SWU, streak = consecutive contested grants.
    int          m_owner;
    int          m_streak;
    int          m_win;
    logic        m_ov;
    logic        m_src;
    logic        m_err;
    logic [1:0]  m_tgt;
    logic [15:0] m_addr;
    logic [31:0] m_data;
    logic        e_hr;
    logic        e_sr;

    vec_t vecs [NV];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(input logic hv, input logic [15:0] ha, input logic [31:0] hd,
                                 input logic sv, input logic [15:0] sa, input logic [7:0] sd,
                                 input logic ordy, input logic kl, input logic rs);
        stim_t s;
        s.hv = hv; s.ha = ha; s.hd = hd;
        s.sv = sv; s.sa = sa; s.sd = sd;
        s.ordy = ordy; s.kl = kl; s.rs = rs;
        return s;
    endfunction

    function automatic vec_t mkv(input stim_t s, input logic hr, input logic sr, input logic ov,
                                 input logic src, input logic [1:0] tgt, input logic [15:0] addr,
                                 input logic [31:0] data, input logic err);
        vec_t v;
        v.in = s; v.hr = hr; v.sr = sr; v.ov = ov; v.src = src;
        v.tgt = tgt; v.addr = addr; v.data = data; v.err = err;
        return v;
    endfunction

    task automatic modelReset();
        m_owner = 1; m_streak = 0; m_win = -1;
        m_ov = 1'b0; m_src = 1'b0; m_err = 1'b0; m_tgt = 2'd0;
        m_addr = 16'h0; m_data = 32'h0;
    endtask

    // Decide who is served this cycle from the fairness rule.
    task automatic modelGrant(input stim_t s);
        int own_v;
        int oth_v;
        m_win = -1;
        if (!s.rs && !s.kl && (!m_ov || s.ordy)) begin
            own_v = (m_owner == 1) ? int'(s.sv) : int'(s.hv);
            oth_v = (m_owner == 1) ? int'(s.hv) : int'(s.sv);
            if (own_v == 1 && (oth_v == 0 || m_streak < MAX_BURST)) m_win = m_owner;
            else if (oth_v == 1) m_win = 1 - m_owner;
        end
        e_hr = (m_win == 0);
        e_sr = (m_win == 1);
    endtask

    task automatic modelStep(input stim_t s);
        logic [15:0] a;
        int          region;
        int          mapped;
        int          loser_v;
        if (s.rs) begin
            modelReset();
        end else if (s.kl) begin
            m_ov = 1'b0; m_streak = 0; m_err = 1'b0;
        end else begin
            a      = (m_win == 0) ? s.ha : s.sa;
            region = int'(a[15:12]);
            mapped = (region >= 1 && region <= 3) ? 1 : 0;
            m_err  = (m_win >= 0 && mapped == 0);
            if (m_win >= 0) begin
                loser_v = (m_win == 0) ? int'(s.sv) : int'(s.hv);
                if (loser_v == 0)          m_streak = 0;
                else if (m_win != m_owner) m_streak = 1;
                else if (m_streak < MAX_BURST) m_streak = m_streak + 1;
                m_owner = m_win;
            end
            if (m_win >= 0 && mapped == 1) begin
                m_ov   = 1'b1;
                m_addr = a;
                m_data = (m_win == 0) ? s.hd : {24'h0, s.sd};
                m_src  = (m_win == 1);
                m_tgt  = 2'(region - 1);
            end else if (s.ordy) begin
                m_ov = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        rst            = s.rs;
        kill           = s.kl;
        bus.host_valid = s.hv;
        bus.host_addr  = s.ha;
        bus.host_data  = s.hd;
        bus.swu_valid  = s.sv;
        bus.swu_addr   = s.sa;
        bus.swu_data   = s.sd;
        bus.out_ready  = s.ordy;
        modelGrant(s);
    endtask

    task automatic finishCycle(input stim_t s);
        modelStep(s);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        chk($sformatf("v%0d_host_ready", idx), 32'(bus.host_ready), 32'(v.hr));
        chk($sformatf("v%0d_swu_ready", idx),  32'(bus.swu_ready),  32'(v.sr));
        chk($sformatf("v%0d_out_valid", idx),  32'(bus.out_valid),  32'(v.ov));
        chk($sformatf("v%0d_err_drop", idx),   32'(bus.err_drop),   32'(v.err));
        if (v.ov) begin
            chk($sformatf("v%0d_out_addr", idx), 32'(bus.out_addr), 32'(v.addr));
            chk($sformatf("v%0d_out_data", idx), bus.out_data,      v.data);
            chk($sformatf("v%0d_out_src", idx),  32'(bus.out_src),  32'(v.src));
            chk($sformatf("v%0d_out_tgt", idx),  32'(bus.out_tgt),  32'(v.tgt));
        end
    endtask

    task automatic checkModel(input int cyc);
        chk($sformatf("rnd%0d_host_ready", cyc), 32'(bus.host_ready), 32'(e_hr));
        chk($sformatf("rnd%0d_swu_ready", cyc),  32'(bus.swu_ready),  32'(e_sr));
        chk($sformatf("rnd%0d_out_valid", cyc),  32'(bus.out_valid),  32'(m_ov));
        chk($sformatf("rnd%0d_err_drop", cyc),   32'(bus.err_drop),   32'(m_err));
        if (m_ov) begin
            chk($sformatf("rnd%0d_out_addr", cyc), 32'(bus.out_addr), 32'(m_addr));
            chk($sformatf("rnd%0d_out_data", cyc), bus.out_data,      m_data);
            chk($sformatf("rnd%0d_out_src", cyc),  32'(bus.out_src),  32'(m_src));
            chk($sformatf("rnd%0d_out_tgt", cyc),  32'(bus.out_tgt),  32'(m_tgt));
        end
    endtask

    task automatic resetDut();
        stim_t s;
        s = mk(1'b1, 16'h1000, 32'h1, 1'b1, 16'h3000, 8'h1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(s);
            @(negedge clk);
            chk("rst_host_ready", 32'(bus.host_ready), 32'd0);
            chk("rst_swu_ready",  32'(bus.swu_ready),  32'd0);
            if (i == 1) begin
                chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
                chk("rst_err_drop",  32'(bus.err_drop),  32'd0);
            end
            finishCycle(s);
        end
    endtask

    initial begin
        stim_t idle;
        stim_t both;
        stim_t s;
        int    g_prev;
        int    g_now;

        rst = 1'b1; kill = 1'b0;
        bus.host_valid = 1'b0; bus.host_addr = '0; bus.host_data = '0;
        bus.swu_valid  = 1'b0; bus.swu_addr  = '0; bus.swu_data  = '0;
        bus.out_ready  = 1'b1;
        modelReset();
        idle = mk(1'b0, 16'h0, 32'h0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 1'b0);
        both = mk(1'b1, 16'h1000, 32'h0000_1111, 1'b1, 16'h3000, 8'h33, 1'b1, 1'b0, 1'b0);

        vecs[0]  = mkv(idle, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 32'h0, 1'b0);
        vecs[1]  = mkv(mk(1'b1, 16'h2005, 32'hDEADBEEF, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 1'b0),
                       1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 32'h0, 1'b0);
        vecs[2]  = mkv(idle, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 16'h2005, 32'hDEADBEEF, 1'b0);
        vecs[3]  = mkv(mk(1'b0, 16'h0, 32'h0, 1'b1, 16'h1234, 8'hA5, 1'b1, 1'b0, 1'b0),
                       1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0, 32'h0, 1'b0);
        vecs[4]  = mkv(mk(1'b0, 16'h0, 32'h0, 1'b1, 16'h7010, 8'h11, 1'b1, 1'b0, 1'b0),
                       1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 16'h1234, 32'h0000_00A5, 1'b0);
        vecs[5]  = mkv(idle, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 32'h0, 1'b1);
        vecs[6]  = mkv(idle, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 32'h0, 1'b0);
        vecs[7]  = mkv(mk(1'b1, 16'h3ABC, 32'h12345678, 1'b1, 16'h2001, 8'h77, 1'b1, 1'b0, 1'b0),
                       1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0, 32'h0, 1'b0);
        vecs[8]  = mkv(mk(1'b1, 16'h3ABC, 32'h12345678, 1'b1, 16'h2002, 8'h78, 1'b1, 1'b0, 1'b0),
                       1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 16'h2001, 32'h0000_0077, 1'b0);
        vecs[9]  = mkv(mk(1'b1, 16'h3ABC, 32'h12345678, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0),
                       1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 16'h2002, 32'h0000_0078, 1'b0);
        vecs[10] = mkv(mk(1'b1, 16'h3ABC, 32'h12345678, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 1'b0),
                       1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 16'h2002, 32'h0000_0078, 1'b0);
        vecs[11] = mkv(idle, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 16'h3ABC, 32'h12345678, 1'b0);
        vecs[12] = mkv(idle, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 32'h0, 1'b0);

        @(posedge clk);
        #1;
        resetDut();
        chk("post_rst_out_addr", 32'(bus.out_addr), 32'd0);
        chk("post_rst_out_data", bus.out_data,      32'd0);
        chk("post_rst_out_src",  32'(bus.out_src),  32'd0);
        chk("post_rst_out_tgt",  32'(bus.out_tgt),  32'd0);

        $display("[TB] directed vector table");
        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].in);
            @(negedge clk);
            checkOutput(vecs[i], i);
            finishCycle(vecs[i].in);
        end
`ifdef PNC_ARB_STATS_EN
        chk("stats_host_gnt", 32'(host_gnt_cnt), 32'd2);
        chk("stats_swu_gnt",  32'(swu_gnt_cnt),  32'd4);
        chk("stats_drop",     32'(drop_cnt),     32'd1);
`endif

        // Both requesters saturated from reset: grants go S x4, H x4, repeating.
        $display("[TB] fairness sequence");
        resetDut();
        g_prev = -1;
        for (int k = 0; k < 17; k++) begin
            g_now = (((k / MAX_BURST) % 2) == 0) ? 1 : 0;
            applyStimulus(both);
            @(negedge clk);
            chk($sformatf("fair%0d_swu_ready", k),  32'(bus.swu_ready),  32'(g_now));
            chk($sformatf("fair%0d_host_ready", k), 32'(bus.host_ready), 32'(1 - g_now));
            if (g_prev >= 0) begin
                chk($sformatf("fair%0d_out_valid", k), 32'(bus.out_valid), 32'd1);
                chk($sformatf("fair%0d_out_src", k),   32'(bus.out_src),   32'(g_prev));
                chk($sformatf("fair%0d_out_tgt", k),   32'(bus.out_tgt),   32'((g_prev == 1) ? 2 : 0));
            end
            finishCycle(both);
            g_prev = g_now;
        end

        $display("[TB] back-pressure sequence");
        resetDut();
        s = mk(1'b1, 16'h2100, 32'hCAFE0001, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(s);
        @(negedge clk);
        chk("bp_first_host_ready", 32'(bus.host_ready), 32'd1);
        finishCycle(s);
        s = mk(1'b1, 16'h2104, 32'hCAFE0002, 1'b1, 16'h3333, 8'h44, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(s);
            @(negedge clk);
            chk($sformatf("bp%0d_host_ready", k), 32'(bus.host_ready), 32'd0);
            chk($sformatf("bp%0d_swu_ready", k),  32'(bus.swu_ready),  32'd0);
            chk($sformatf("bp%0d_out_valid", k),  32'(bus.out_valid),  32'd1);
            chk($sformatf("bp%0d_out_data", k),   bus.out_data,        32'hCAFE0001);
            chk($sformatf("bp%0d_out_addr", k),   32'(bus.out_addr),   32'h2100);
            finishCycle(s);
        end
        s = mk(1'b1, 16'h2104, 32'hCAFE0002, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(s);
        @(negedge clk);
        chk("bp_release_host_ready", 32'(bus.host_ready), 32'd1);
        chk("bp_release_out_data",   bus.out_data,        32'hCAFE0001);
        finishCycle(s);
        applyStimulus(idle);
        @(negedge clk);
        chk("bp_next_out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_next_out_data",  bus.out_data,       32'hCAFE0002);
        finishCycle(idle);

        // Kill after three SWU grants: burst restarts so SWU keeps four more grants.
        $display("[TB] kill sequence");
        resetDut();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(both);
            @(negedge clk);
            chk($sformatf("kill_pre%0d_swu_ready", k), 32'(bus.swu_ready), 32'd1);
            finishCycle(both);
        end
        s = both;
        s.kl = 1'b1;
        applyStimulus(s);
        @(negedge clk);
        chk("kill_cycle_out_valid",  32'(bus.out_valid),  32'd1);
        chk("kill_cycle_host_ready", 32'(bus.host_ready), 32'd0);
        chk("kill_cycle_swu_ready",  32'(bus.swu_ready),  32'd0);
        finishCycle(s);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(both);
            @(negedge clk);
            if (k == 0) chk("kill_after_out_valid", 32'(bus.out_valid), 32'd0);
            if (k == 1) chk("kill_resume_out_valid", 32'(bus.out_valid), 32'd1);
            chk($sformatf("kill_post%0d_swu_ready", k),  32'(bus.swu_ready),  32'((k < 4) ? 1 : 0));
            chk($sformatf("kill_post%0d_host_ready", k), 32'(bus.host_ready), 32'((k < 4) ? 0 : 1));
            finishCycle(both);
        end

        $display("[TB] randomized traffic against reference model");
        resetDut();
        for (int c = 0; c < 2000; c++) begin
            s.hv   = ($urandom_range(0, 3) != 0);
            s.ha   = {4'($urandom_range(0, 5)), 12'($urandom)};
            s.hd   = $urandom;
            s.sv   = ($urandom_range(0, 3) != 0);
            s.sa   = {4'($urandom_range(0, 5)), 12'($urandom)};
            s.sd   = 8'($urandom);
            s.ordy = ($urandom_range(0, 3) != 0);
            s.kl   = ($urandom_range(0, 39) == 0);
            s.rs   = ($urandom_range(0, 199) == 0);
            applyStimulus(s);
            @(negedge clk);
            checkModel(c);
            finishCycle(s);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/pnc_req_arbiter.md
# pnc_req_arbiter

Two-requester arbiter and registered issue stage placed in front of the physical neuron controller's address/data stack machines. It shares the single PNC write path between the host access port (address plus 32-bit word) and the software-update (SWU) port (address plus 8-bit byte). Selection is round-robin with a burst limit. The block also decodes the target engine (synapse, soma or STDP) and drops requests to unmapped regions. Output is a one-entry valid/ready register, so downstream back-pressure stalls both requesters cleanly.

## Interface
- ADDR_W, 16, address width of both requesters and the output
- DATA_W, 32, host and output data width
- SWU_DATA_W, 8, SWU data width; zero-extended to DATA_W
- MAX_BURST, 4, maximum consecutive grants to one requester while the other is waiting (range 1..15)

- clk  in  1  single clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- kill  in  1  synchronous flush of in-flight state; arbitration owner is kept
- host_valid / host_ready  in / out  1 / 1  host request handshake
- host_addr / host_data  in  ADDR_W / DATA_W  host request payload
- swu_valid / swu_ready  in / out  1 / 1  SWU request handshake
- swu_addr / swu_data  in  ADDR_W / SWU_DATA_W  SWU request payload
- out_valid / out_ready  out / in  1 / 1  issue handshake to the PNC
- out_addr / out_data  out  ADDR_W / DATA_W  issued payload
- out_src  out  1  0 = host, 1 = SWU
- out_tgt  out  2  0 = synapse, 1 = soma, 2 = STDP
- err_drop  out  1  one-cycle pulse when an accepted request had an unmapped target

## Operation
- A transfer on any port occurs when valid & ready are both high at a clock edge.
- Issue register: `slot_free = !out_valid | out_ready`. While `slot_free & !kill & !rst`, host_ready and swu_ready are driven by the grant logic; otherwise both are 0.
- Only the granted requester sees ready = 1; ready is never high on both ports in the same cycle. Ready may depend combinationally on valid.
- Owner FSM has states OWN_HOST and OWN_SWU, plus burst_cnt (4 bits):
  - The owner keeps the grant while its valid is 1 and (other valid is 0, or burst_cnt < MAX_BURST).
  - Grant switches to the other requester when the owner is idle and the other is valid, or when burst_cnt == MAX_BURST and the other is valid.
  - When the grant switches, the state moves to the new owner and burst_cnt = 1 after the transfer.
  - A transfer by the current owner increments burst_cnt, saturating at MAX_BURST.
  - burst_cnt is cleared to 0 when a transfer happens with the other requester not valid.
- Target decode from addr[15:12]:
  - 4'h1 gives synapse (0), 4'h2 gives soma (1), 4'h3 gives STDP (2).
  - Any other code is accepted (handshake completes, counts toward the burst) but is not loaded into the issue register; err_drop pulses the following cycle.
- SWU data is loaded as {24'b0, swu_data}.
- kill: clears out_valid, burst_cnt and err_drop on the next edge. The owner state is unchanged. No input is accepted in the kill cycle.

## Timing
- Reset values: out_valid=0, out_addr=0, out_data=0, out_src=0, out_tgt=0, err_drop=0, host_ready=0, swu_ready=0 (during rst), owner=OWN_SWU, burst_cnt=0.
- Latency: a request accepted at edge N appears with out_valid=1 after edge N, i.e. in cycle N+1.
- Throughput is one request per cycle while out_ready stays 1.
- out_valid=1 with out_ready=0: out_* hold stable and both readies are 0.
- Simultaneous drain and accept in one cycle is allowed; the register reloads with no bubble.
- Both requesters valid from reset with MAX_BURST=4: the grant sequence is S,S,S,S,H,H,H,H,S…
- rst has priority over kill. kill has priority over any handshake in the same cycle.

## Configuration
- PNC_ARB_STATS_EN defined:
  - Adds outputs host_gnt_cnt[15:0], swu_gnt_cnt[15:0] and drop_cnt[15:0].
  - Each is a saturating count of accepted host, accepted SWU and dropped requests.
  - All three are cleared by rst only, not by kill.
- Not defined: these ports and counters do not exist. Functional behaviour is otherwise identical.

## Structure
- Shared package pnc_pkg holds:
  - Target codes: TGT_SYNAPSE=2'd0, TGT_SOMA=2'd1, TGT_STDP=2'd2.
  - Region constants: REGION_SYNAPSE=4'h1, REGION_SOMA=4'h2, REGION_STDP=4'h3.
  - Owner enum: OWN_HOST, OWN_SWU.
- One sub-module, pnc_tgt_decode: combinational addr[15:12] → {hit, tgt}. It is reused later by the PNC address control path.
- The arbiter FSM, the issue register and the optional stats counters stay in the top module.

## Test plan
- Reset/idle: assert rst 2 cycles, then no valids → out_valid=0, both readies 0 during rst, owner=OWN_SWU, err_drop=0.
- Single host write: host_addr=16'h2005, host_data=32'hDEADBEEF, out_ready=1 → next cycle out_valid=1, out_tgt=1, out_src=0, out_data=32'hDEADBEEF.
- Fairness: both valid continuously with addr 16'h1000 / 16'h3000, MAX_BURST=4 → out_src pattern is 1,1,1,1,0,0,0,0 repeating, with no idle cycles.
- Back-pressure: hold out_ready=0 for 5 cycles with a request issued → out_* stable, both readies 0; when out_ready returns to 1, the next request issues with no bubble.
- Unmapped target: swu_addr=16'h7010 → swu_ready=1 for that cycle, out_valid stays 0, err_drop=1 for exactly one cycle; with PNC_ARB_STATS_EN, drop_cnt goes to 1.
- Kill mid-stream: assert kill while out_valid=1 and burst_cnt=3 → out_valid=0 next cycle, burst_cnt=0, owner unchanged, and traffic resumes the cycle after kill deasserts.
